// File: rtl/seven_segment_reader.sv
// Samples a multiplexed seven-segment display, debounces each digit strobe and
// assembles four decoded BCD digits into a frame delivered over a valid/ready handshake.
module seven_segment_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  digit_sel,
  output logic [15:0] out_value,
  output logic [3:0]  out_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

  logic [6:0]       prev_seg;
  logic [3:0]       prev_sel;
  logic             prev_ok;
  logic [CNT_W-1:0] run_cnt;
  logic             captured;
  logic [3:0]       mask;
  logic [15:0]      slot_value;
  logic [3:0]       slot_err;

  logic             one_hot_c;
  logic             same_c;
  logic [CNT_W-1:0] cnt_next_c;
  logic             captured_next_c;
  logic             capture_c;
  logic             frame_done_c;
  logic [1:0]       idx_c;
  logic [3:0]       dec_bcd_c;
  logic             dec_err_c;
  logic [15:0]      slot_value_next_c;
  logic [3:0]       slot_err_next_c;

  assign one_hot_c = (digit_sel != 4'd0) && ((digit_sel & (digit_sel - 4'd1)) == 4'd0);
  assign same_c    = prev_ok && (seg == prev_seg) && (digit_sel == prev_sel);

  // Segment pattern to BCD; anything unrecognised is flagged and reads back as F.
  always_comb begin
    dec_bcd_c = 4'hF;
    dec_err_c = 1'b0;
    case (seg)
      7'b1111110: dec_bcd_c = 4'd0;
      7'b0110000: dec_bcd_c = 4'd1;
      7'b1101101: dec_bcd_c = 4'd2;
      7'b1111001: dec_bcd_c = 4'd3;
      7'b0110011: dec_bcd_c = 4'd4;
      7'b1011011: dec_bcd_c = 4'd5;
      7'b1011111: dec_bcd_c = 4'd6;
      7'b1110000: dec_bcd_c = 4'd7;
      7'b1111111: dec_bcd_c = 4'd8;
      7'b1111011: dec_bcd_c = 4'd9;
      default:    dec_err_c = 1'b1;
    endcase
  end

  always_comb begin
    idx_c = 2'd0;
    case (digit_sel)
      4'b0010: idx_c = 2'd1;
      4'b0100: idx_c = 2'd2;
      4'b1000: idx_c = 2'd3;
      default: idx_c = 2'd0;
    endcase
  end

  // Run counter saturates at STABLE so a long hold never re-triggers a capture.
  always_comb begin
    cnt_next_c      = '0;
    captured_next_c = 1'b0;
    capture_c       = 1'b0;
    if (one_hot_c) begin
      if (same_c) begin
        cnt_next_c      = (run_cnt >= STABLE) ? STABLE : run_cnt + CNT_W'(1);
        captured_next_c = captured;
      end else begin
        cnt_next_c      = CNT_W'(1);
        captured_next_c = 1'b0;
      end
      capture_c       = (cnt_next_c == STABLE) && !captured_next_c;
      captured_next_c = captured_next_c | capture_c;
    end
  end

  always_comb begin
    slot_value_next_c = slot_value;
    slot_err_next_c   = slot_err;
    if (capture_c) begin
      slot_value_next_c[4*idx_c +: 4] = dec_bcd_c;
      slot_err_next_c[idx_c]          = dec_err_c;
    end
  end

  assign frame_done_c = capture_c && ((mask | digit_sel) == 4'(2**NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_seg   <= '0;
      prev_sel   <= '0;
      prev_ok    <= 1'b0;
      run_cnt    <= '0;
      captured   <= 1'b0;
      mask       <= '0;
      slot_value <= '0;
      slot_err   <= '0;
      out_value  <= '0;
      out_err    <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      prev_seg   <= seg;
      prev_sel   <= digit_sel;
      prev_ok    <= 1'b1;
      run_cnt    <= cnt_next_c;
      captured   <= captured_next_c;
      slot_value <= slot_value_next_c;
      slot_err   <= slot_err_next_c;

      if (frame_done_c) begin
        mask <= '0;
      end else if (capture_c) begin
        mask <= mask | digit_sel;
      end

      // A completed frame either replaces the held one or is dropped while the consumer stalls.
      if (frame_done_c) begin
        if (!out_valid || out_ready) begin
          out_value <= slot_value_next_c;
          out_err   <= slot_err_next_c;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Self-checking bench for seven_segment_reader: scoreboarded frame delivery plus
// scenario tasks for debounce, decode errors, back-pressure, reset and a fast instance.
module tb_seven_segment_reader;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  e;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;
  logic [15:0] out_value;
  logic [3:0]  out_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  logic [6:0]  seg1;
  logic [3:0]  sel1;
  logic [15:0] value1;
  logic [3:0]  err1;
  logic        valid1;
  logic        ready1;
  logic        overrun1;

  int checks = 0;
  int errors = 0;
  frame_t sb[$];

  always #5 clk = ~clk;

  seven_segment_reader #(.STABLE_CYCLES(4)) u_dut (
    .clk(clk), .reset(reset), .seg(seg), .digit_sel(digit_sel),
    .out_value(out_value), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun)
  );

  seven_segment_reader #(.STABLE_CYCLES(1)) u_dut_fast (
    .clk(clk), .reset(reset), .seg(seg1), .digit_sel(sel1),
    .out_value(value1), .out_err(err1), .out_valid(valid1),
    .out_ready(ready1), .overrun(overrun1)
  );

  function automatic logic [6:0] pat(input int v);
    case (v)
      0: pat = 7'b1111110;
      1: pat = 7'b0110000;
      2: pat = 7'b1101101;
      3: pat = 7'b1111001;
      4: pat = 7'b0110011;
      5: pat = 7'b1011011;
      6: pat = 7'b1011111;
      7: pat = 7'b1110000;
      8: pat = 7'b1111111;
      9: pat = 7'b1111011;
      default: pat = 7'b0000000;
    endcase
  endfunction

  // Accepted frames are popped from the scoreboard and compared.
  always @(negedge clk) begin : monitor
    frame_t exp;
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got frame value=%h err=%b, expected no frame", out_value, out_err);
      end else begin
        exp = sb.pop_front();
        if (out_value !== exp.v || out_err !== exp.e) begin
          errors++;
          $display("FAIL sb_frame: got value=%h err=%b, expected value=%h err=%b",
                   out_value, out_err, exp.v, exp.e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
    seg = s;
    digit_sel = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v, input logic [3:0] e);
    frame_t f;
    f.v = v;
    f.e = e;
    sb.push_back(f);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    out_ready = 1'b1;
    ready1 = 1'b1;
    seg = '0;
    digit_sel = '0;
    seg1 = '0;
    sel1 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_value !== 16'h0 || out_err !== 4'h0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got value=%h err=%b valid=%b overrun=%b, expected all zero",
               out_value, out_err, out_valid, overrun);
    end
    checks++;
    if (value1 !== 16'h0 || err1 !== 4'h0 || valid1 !== 1'b0 || overrun1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_fast: got value=%h err=%b valid=%b overrun=%b, expected all zero",
               value1, err1, valid1, overrun1);
    end
    reset = 1'b0;
  endtask

  task automatic test_scan;
    drive(7'd0, 4'd0, 1);
    push(16'h4321, 4'h0);
    drive(pat(1), 4'b0001, 4);
    drive(pat(2), 4'b0010, 4);
    drive(pat(3), 4'b0100, 4);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL scan_early_valid: got %b expected 0", out_valid);
    end
    drive(pat(4), 4'b1000, 4);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 16'h4321 || out_err !== 4'h0) begin
      errors++;
      $display("FAIL scan_latency: got valid=%b value=%h err=%b, expected 1 4321 0000",
               out_valid, out_value, out_err);
    end
    drive(pat(4), 4'b1000, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL scan_one_cycle: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_short_hold;
    drive(7'd0, 4'd0, 1);
    drive(pat(1), 4'b0001, 4);
    drive(pat(2), 4'b0010, 4);
    drive(pat(3), 4'b0100, 3);
    drive(7'd0, 4'd0, 2);
    drive(pat(4), 4'b1000, 4);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL short_hold_captured: got valid=%b expected 0", out_valid);
    end
    push(16'h4321, 4'h0);
    drive(pat(3), 4'b0100, 4);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 16'h4321) begin
      errors++;
      $display("FAIL short_hold_complete: got valid=%b value=%h, expected 1 4321", out_valid, out_value);
    end
  endtask

  task automatic test_blank_digit;
    drive(7'd0, 4'd0, 1);
    push(16'h43F1, 4'b0010);
    drive(pat(1), 4'b0001, 4);
    drive(7'b0000000, 4'b0010, 4);
    drive(pat(3), 4'b0100, 4);
    drive(pat(4), 4'b1000, 4);
    checks++;
    if (out_valid !== 1'b1 || out_value[7:4] !== 4'hF || out_err !== 4'b0010) begin
      errors++;
      $display("FAIL blank_digit: got valid=%b nibble=%h err=%b, expected 1 F 0010",
               out_valid, out_value[7:4], out_err);
    end
  endtask

  task automatic test_back_to_back;
    drive(7'd0, 4'd0, 1);
    out_ready = 1'b0;
    push(16'h8765, 4'h0);
    drive(pat(5), 4'b0001, 4);
    drive(pat(6), 4'b0010, 4);
    drive(pat(7), 4'b0100, 4);
    drive(pat(8), 4'b1000, 4);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 16'h8765 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL first_frame: got valid=%b value=%h overrun=%b, expected 1 8765 0",
               out_valid, out_value, overrun);
    end
    drive(pat(9), 4'b0001, 4);
    drive(pat(0), 4'b0010, 4);
    drive(pat(1), 4'b0100, 4);
    drive(pat(2), 4'b1000, 4);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 16'h8765 || out_err !== 4'h0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_hold: got valid=%b value=%h err=%b overrun=%b, expected 1 8765 0000 1",
               out_valid, out_value, out_err, overrun);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_release: got valid=%b overrun=%b, expected 0 1", out_valid, overrun);
    end
  endtask

  task automatic test_bad_sel_and_reset;
    drive(7'd0, 4'd0, 1);
    drive(pat(8), 4'b0011, 10);
    drive(pat(7), 4'b0100, 4);
    drive(pat(7), 4'b1000, 4);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL multi_sel_captured: got valid=%b expected 0", out_valid);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (out_value !== 16'h0 || out_err !== 4'h0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: got value=%h err=%b valid=%b overrun=%b, expected all zero",
               out_value, out_err, out_valid, overrun);
    end
    drive(pat(1), 4'b0001, 4);
    drive(pat(2), 4'b0010, 4);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mask_not_cleared: got valid=%b expected 0", out_valid);
    end
    push(16'h4321, 4'h0);
    drive(pat(3), 4'b0100, 4);
    drive(pat(4), 4'b1000, 4);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 16'h4321) begin
      errors++;
      $display("FAIL post_reset_frame: got valid=%b value=%h, expected 1 4321", out_valid, out_value);
    end
  endtask

  task automatic test_fast;
    logic [3:0] sel;
    sel = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        checks++;
        if (valid1 !== 1'b0) begin
          errors++;
          $display("FAIL fast_early_valid: got %b expected 0", valid1);
        end
      end
      seg1 = pat(k + 1);
      sel1 = sel;
      sel = sel << 1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (valid1 !== 1'b1 || value1 !== 16'h4321 || err1 !== 4'h0) begin
      errors++;
      $display("FAIL fast_frame: got valid=%b value=%h err=%b, expected 1 4321 0000",
               valid1, value1, err1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (valid1 !== 1'b0) begin
      errors++;
      $display("FAIL fast_one_cycle: got valid=%b expected 0", valid1);
    end
  endtask

  task automatic test_drain;
    drive(7'd0, 4'd0, 2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d frames pending, expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_short_hold();
    test_blank_digit();
    test_back_to_back();
    test_bad_sel_and_reset();
    test_fast();
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
